data_stack: RTL and testbench

- Parameterised LIFO operand stack feeding the 16-bit ALU in the CSM datapath.
- Top-of-stack (TOS) and next-on-stack (NOS) are registered outputs that drive the ALU's i_arg0 and i_arg1 directly.
- The ALU's registered result is written back with a drop-and-replace operation, so a binary ALU op consumes two items and yields one.
- Implemented as a register shift-stack so TOS and NOS are available with zero read latency.

---
 rtl/data_stack_pkg.sv | 36 +++
 rtl/data_stack_if.sv | 29 ++
 rtl/data_stack.sv | 167 ++++++++++++++++
 tb/tb_data_stack.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/data_stack_pkg.sv
// Shared operation encodings and legality helpers for the operand stack.
package data_stack_pkg;

  localparam int unsigned DS_OP_W  = 3;
  localparam int unsigned DS_MIN_W = 2;

  // Stack operations; DS_ prefix keeps them apart from the ALU op names.
  typedef enum logic [DS_OP_W-1:0] {
    DS_NONE = 3'd0,
    DS_DROP = 3'd1,
    DS_PUSH = 3'd2,
    DS_RPLC = 3'd3,
    DS_DRPR = 3'd4,
    DS_SWAP = 3'd5,
    DS_DUP  = 3'd6,
    DS_OVER = 3'd7
  } ds_op_e;

  // Minimum number of valid items an op needs before it may execute.
  function automatic logic [DS_MIN_W-1:0] op_min_count(input ds_op_e op);
    logic [DS_MIN_W-1:0] min_cnt;
    min_cnt = DS_MIN_W'(0);
    case (op)
      DS_DROP, DS_RPLC, DS_DUP: min_cnt = DS_MIN_W'(1);
      DS_DRPR, DS_SWAP, DS_OVER: min_cnt = DS_MIN_W'(2);
      default: min_cnt = DS_MIN_W'(0);
    endcase
    return min_cnt;
  endfunction

  // Ops that add an item and therefore need a free cell.
  function automatic logic op_grows(input ds_op_e op);
    return (op == DS_PUSH) || (op == DS_DUP) || (op == DS_OVER);
  endfunction

endpackage

// File: rtl/data_stack_if.sv
// Command/status bundle between the stack controller and the operand stack.
interface data_stack_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 12
);
  import data_stack_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               i_se;
  logic [DS_OP_W-1:0] i_op;
  logic [WIDTH-1:0]   i_data;
  logic [WIDTH-1:0]   o_s0;
  logic [WIDTH-1:0]   o_s1;
  logic [CNT_W-1:0]   o_count;
  logic               o_underflow;
  logic               o_overflow;

  modport master (
    output i_se, i_op, i_data,
    input  o_s0, o_s1, o_count, o_underflow, o_overflow
  );

  modport slave (
    input  i_se, i_op, i_data,
    output o_s0, o_s1, o_count, o_underflow, o_overflow
  );

endinterface

// File: rtl/data_stack.sv
// Register shift-stack: TOS/NOS come straight from flops for zero read latency.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 12
) (
  input  logic         i_clk,
  input  logic         i_rst,
  data_stack_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ds_op_e           op;
  logic             under;
  logic             over;
  logic             legal;
  logic             shift_up;
  logic             shift_down;
  logic             swap;
  logic             top_load;
  logic [WIDTH-1:0] top_val;

  logic [CNT_W-1:0] count_d, count_q;
  logic             underflow_d, underflow_q;
  logic             overflow_d, overflow_q;

  logic [WIDTH-1:0] s_q [DEPTH];

  // Decode the op, check it against the item count and derive cell controls.
  always_comb begin
    op          = bus.i_se ? ds_op_e'(bus.i_op) : DS_NONE;
    under       = count_q < CNT_W'(op_min_count(op));
    over        = op_grows(op) && (count_q == CNT_W'(DEPTH));
    legal       = !under && !over;

    shift_up    = 1'b0;
    shift_down  = 1'b0;
    swap        = 1'b0;
    top_load    = 1'b0;
    top_val     = s_q[0];
    count_d     = count_q;
    underflow_d = underflow_q | under;
    overflow_d  = overflow_q | (over && !under);

    if (legal) begin
      case (op)
        DS_DROP: begin
          shift_down = 1'b1;
          count_d    = count_q - CNT_W'(1);
        end
        DS_PUSH: begin
          shift_up = 1'b1;
          top_load = 1'b1;
          top_val  = bus.i_data;
          count_d  = count_q + CNT_W'(1);
        end
        DS_RPLC: begin
          top_load = 1'b1;
          top_val  = bus.i_data;
        end
        DS_DRPR: begin
          shift_down = 1'b1;
          top_load   = 1'b1;
          top_val    = bus.i_data;
          count_d    = count_q - CNT_W'(1);
        end
        DS_SWAP: begin
          swap     = 1'b1;
          top_load = 1'b1;
          top_val  = s_q[1];
        end
        DS_DUP: begin
          shift_up = 1'b1;
          top_load = 1'b1;
          top_val  = s_q[0];
          count_d  = count_q + CNT_W'(1);
        end
        DS_OVER: begin
          shift_up = 1'b1;
          top_load = 1'b1;
          top_val  = s_q[1];
          count_d  = count_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Cell array: each cell picks hold, its upper neighbour, its lower neighbour or a load.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] cell_q;
    logic [WIDTH-1:0] below;

    if (i == DEPTH - 1) begin : g_bottom
      assign below = '0;
    end else begin : g_inner
      assign below = s_q[i+1];
    end

    if (i == 0) begin : g_tos
      // TOS takes a load first, otherwise pulls NOS up on a drop.
      always_comb begin
        cell_d = cell_q;
        if (top_load) begin
          cell_d = top_val;
        end else if (shift_down) begin
          cell_d = below;
        end
      end
    end else if (i == 1) begin : g_nos
      // NOS receives the old TOS on a swap or push, else follows the shift.
      always_comb begin
        cell_d = cell_q;
        if (swap || shift_up) begin
          cell_d = s_q[0];
        end else if (shift_down) begin
          cell_d = below;
        end
      end
    end else begin : g_deep
      // Deeper cells only ever shift.
      always_comb begin
        cell_d = cell_q;
        if (shift_up) begin
          cell_d = s_q[i-1];
        end else if (shift_down) begin
          cell_d = below;
        end
      end
    end

    // Cell storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cell_q <= '0;
      end else begin
        cell_q <= cell_d;
      end
    end

    assign s_q[i] = cell_q;
  end

  // Item count and sticky error flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.o_s0        = s_q[0];
  assign bus.o_s1        = s_q[1];
  assign bus.o_count     = count_q;
  assign bus.o_underflow = underflow_q;
  assign bus.o_overflow  = overflow_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed test of the operand stack with hand-computed expectations.
module tb_data_stack;
  import data_stack_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 12;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [WIDTH-1:0] alu_q;
  logic             alu_en;

  data_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal registered ALU ADD fed from TOS/NOS.
  always_ff @(posedge clk) begin
    if (alu_en) alu_q <= bus.o_s0 + bus.o_s1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input ds_op_e op, input logic [WIDTH-1:0] data);
    bus.i_se   = 1'b1;
    bus.i_op   = op;
    bus.i_data = data;
    @(posedge clk);
    #1;
    bus.i_op   = DS_NONE;
    bus.i_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expect_state(input string tag, input int s0, input int s1, input int cnt,
                              input int uf, input int ovf);
    check({tag, "_s0"}, 32'(bus.o_s0), 32'(s0));
    check({tag, "_s1"}, 32'(bus.o_s1), 32'(s1));
    check({tag, "_count"}, 32'(bus.o_count), 32'(cnt));
    check({tag, "_uf"}, 32'(bus.o_underflow), 32'(uf));
    check({tag, "_of"}, 32'(bus.o_overflow), 32'(ovf));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    alu_en     = 1'b0;
    alu_q      = '0;
    rst        = 1'b1;
    bus.i_se   = 1'b1;
    bus.i_op   = DS_NONE;
    bus.i_data = '0;
    #1;
    expect_state("reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic push ordering.
    step(DS_PUSH, 16'd5);
    step(DS_PUSH, 16'd8);
    step(DS_NONE, 16'd0);
    expect_state("push2", 8, 5, 2, 0, 0);

    // Stack manipulation ops from {8,5}.
    step(DS_SWAP, 16'd0);
    expect_state("swap", 5, 8, 2, 0, 0);
    step(DS_DUP, 16'd0);
    expect_state("dup", 5, 5, 3, 0, 0);
    step(DS_OVER, 16'd0);
    expect_state("over", 5, 5, 4, 0, 0);
    step(DS_DROP, 16'd0);
    step(DS_DROP, 16'd0);
    expect_state("drop2", 5, 8, 2, 0, 0);

    // ALU pairing: NONE while ALU samples, then drop-and-replace with its result.
    do_reset();
    step(DS_PUSH, 16'd5);
    step(DS_PUSH, 16'd8);
    alu_en = 1'b1;
    step(DS_NONE, 16'd0);
    alu_en = 1'b0;
    step(DS_DRPR, alu_q);
    expect_state("alu_add", 13, 0, 1, 0, 0);

    // Fill to DEPTH then overflow.
    do_reset();
    for (int k = 1; k <= 12; k++) step(DS_PUSH, WIDTH'(k));
    expect_state("full", 12, 11, 12, 0, 0);
    step(DS_PUSH, 16'd99);
    expect_state("overflow", 12, 11, 12, 0, 1);
    step(DS_DROP, 16'd0);
    expect_state("drop_after_of", 11, 10, 11, 0, 1);

    // Underflow from empty, flag stays sticky and does not block.
    do_reset();
    step(DS_DROP, 16'd0);
    expect_state("underflow", 0, 0, 0, 1, 0);
    step(DS_PUSH, 16'd7);
    expect_state("push_after_uf", 7, 0, 1, 1, 0);
    step(DS_DRPR, 16'd42);
    expect_state("drpr_one_item", 7, 0, 1, 1, 0);

    // Stack enable low ignores the op.
    do_reset();
    bus.i_se   = 1'b0;
    bus.i_op   = DS_PUSH;
    bus.i_data = 16'd3;
    @(posedge clk);
    #1;
    bus.i_se   = 1'b1;
    bus.i_op   = DS_NONE;
    expect_state("se_low", 0, 0, 0, 0, 0);

    // Asynchronous reset between edges.
    step(DS_PUSH, 16'd1);
    step(DS_PUSH, 16'd2);
    step(DS_PUSH, 16'd3);
    expect_state("pre_async", 3, 2, 3, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    expect_state("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(DS_PUSH, 16'd4);
    expect_state("post_rst", 4, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
